syscall_console: RTL and testbench
==================================

// Module: syscall_console
// PURPOSE
//  Output stage directly downstream of the syscall execute unit (instruction ID 26).
//  Accepts one print/exit/nop request per handshake: syscall code plus up to four 32-bit words.
//  Formats the request into an ASCII byte stream: signed or unsigned decimal, or packed strings.
//  Streams the bytes to the console sink under valid/ready; latches a sticky halt on exit.
// PARAMETERS
//  NEWLINE_EN    1  1: append 0x0A after each print request; 0: no terminator
//  STR_NUL_TERM  1  1: a 0x00 byte ends the string early; 0: NUL bytes are emitted
// PORTS
//  clk        in   1   single clock; all state updates on posedge
//  reset      in   1   synchronous, active-high
//  req_valid  in   1   request present
//  req_ready  out  1   request accepted when req_valid && req_ready
//  req_code   in   32  syscall code (rs): 1 sint, 2 exit, 3 nop, 4..7 string, 8 uint
//  req_w0     in   32  integer operand, or string chars 0-3
//  req_w1     in   32  string chars 4-7
//  req_w2     in   32  string chars 8-11
//  req_w3     in   32  string chars 12-15
//  ch_valid   out  1   ch_data holds a valid byte
//  ch_ready   in   1   sink takes the byte when ch_valid && ch_ready
//  ch_data    out  8   ASCII byte
//  halted     out  1   sticky; set by code 2
//  busy       out  1   request in progress (state != IDLE/HALT)
//  bad_code   out  1   one-cycle pulse when an unsupported code is accepted
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; ch_valid=0; ch_data=0; halted=0; busy=0; bad_code=0.
//  Reset mid-request discards the request and any partly emitted output.
//  req_ready=1 only in IDLE. Request fields are captured at accept. Inputs are ignored otherwise.
//  States and transitions:
//   - IDLE: on accept, dispatch by code.
//   - Code 1, value negative: go to SIGN and emit '-'. Magnitude = two's-complement negation,
//     taken unsigned, so 0x80000000 -> 2147483648.
//   - Code 1 non-negative, or code 8: go to DIGIT with magnitude = operand as unsigned.
//   - DIGIT: walk POW10[9]..POW10[0]. Per power, subtract once per cycle while mag>=pow,
//     counting d (0..9, max 9 cycles per power).
//     Emit '0'+d (EMIT state) if d!=0, or a nonzero digit was already emitted, or pow==1.
//     Otherwise skip with no emit cycle. Zero prints as "0".
//   - Codes 4..7: STR emits 4*(code-3) bytes, w0..w3 in order, MSB byte of each word first
//     ("ABCD" -> 'A','B','C','D'). STR_NUL_TERM=1: the first 0x00 ends the string early.
//   - After the last char: NL (if NEWLINE_EN), then IDLE.
//   - Code 3: accepted; return to IDLE next cycle; no bytes.
//   - Code 2: go to HALT; halted=1 from the next cycle. Stay in HALT until reset;
//     req_ready=0, ch_valid=0.
//   - Any other code: accepted; bad_code pulses for 1 cycle; return to IDLE; no bytes.
//  Output handshake:
//   - ch_valid may assert without waiting for ch_ready.
//   - Once asserted, ch_valid and ch_data stay stable until ch_ready.
//   - Advance exactly one byte per ch_valid&&ch_ready cycle.
//   - ch_ready held low stalls the FSM indefinitely; no bytes lost or duplicated.
//  Latency: first byte valid 1 cycle after accept for sign/string; after digit search for ints.
//  Back-to-back requests: the next accept is possible in the cycle after the final byte
//  handshake. There is no input overlap.
// STRUCTURE
//  Package syscall_pkg:
//   - code constants SYS_PRINT_INT=1, SYS_EXIT=2, SYS_NOP=3, SYS_STR4..SYS_STR16=4..7,
//     SYS_PRINT_UINT=8
//   - POW10[0:9] 32-bit table
//   - state enum {IDLE,SIGN,DIGIT,EMIT,STR,NL,HALT}
//  Sub-module syscall_dec_digit: magnitude register, power index, subtract loop, leading-zero flag.
//  Its outputs are digit_valid/digit/last, with a digit_ack input. The top holds FSM + byte mux.
// TESTING
//  code1, w0=-1001 -> bytes '-','1','0','0','1',0x0A; then req_ready=1.
//  code8, w0=0xFFFFFC17 -> "4294966295",0x0A. code1, w0=0x80000000 -> "-2147483648",0x0A.
//  code1, w0=0 -> "0",0x0A.
//  code7, w0..w3="ABCD","EFGH","IJKL","MNOP" with ch_ready toggling randomly ->
//   exactly "ABCDEFGHIJKLMNOP",0x0A; data stable while stalled.
//  code5, w0="AB\0\0" -> "AB",0x0A. code3 -> no bytes, busy low after 1 cycle.
//  code 9 -> bad_code pulse, no bytes.
//  code2 -> halted=1, req_ready stays 0 for 100 cycles; reset -> halted=0, req_ready=1.
//  Reset asserted during digit search of 4294966295 -> ch_valid=0 next cycle, state IDLE.
//  A following code1, w0=7 gives "7",0x0A.

Source files
------------

// File: rtl/syscall_console_pkg.sv
// Shared constants, state encoding and request decode helpers for the syscall console.
package syscall_pkg;

   localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
   localparam logic [31:0] SYS_EXIT       = 32'd2;
   localparam logic [31:0] SYS_NOP        = 32'd3;
   localparam logic [31:0] SYS_STR4       = 32'd4;
   localparam logic [31:0] SYS_STR8       = 32'd5;
   localparam logic [31:0] SYS_STR12      = 32'd6;
   localparam logic [31:0] SYS_STR16      = 32'd7;
   localparam logic [31:0] SYS_PRINT_UINT = 32'd8;

   localparam logic [31:0] POW10 [0:9] = '{
      32'd1, 32'd10, 32'd100, 32'd1000, 32'd10000, 32'd100000,
      32'd1000000, 32'd10000000, 32'd100000000, 32'd1000000000
   };

   localparam logic [7:0] ASCII_0     = 8'h30;
   localparam logic [7:0] ASCII_MINUS = 8'h2D;
   localparam logic [7:0] ASCII_NL    = 8'h0A;

   typedef enum logic [2:0] {IDLE, SIGN, DIGIT, EMIT, STR, NL, HALT} state_t;

   function automatic logic is_str(input logic [31:0] code);
      return (code >= SYS_STR4) && (code <= SYS_STR16);
   endfunction

   function automatic logic code_known(input logic [31:0] code);
      return (code >= SYS_PRINT_INT) && (code <= SYS_PRINT_UINT);
   endfunction

   // 4 bytes per word: code 4 -> 4 bytes ... code 7 -> 16 bytes
   function automatic logic [4:0] str_bytes(input logic [31:0] code);
      return {code[2:0] - 3'd3, 2'b00};
   endfunction

endpackage

// File: rtl/syscall_console_if.sv
// Request and character-stream handshake bundle between execute unit, console and sink.
interface syscall_console_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_code;
   logic [31:0] req_w0;
   logic [31:0] req_w1;
   logic [31:0] req_w2;
   logic [31:0] req_w3;
   logic        ch_valid;
   logic        ch_ready;
   logic [7:0]  ch_data;

   modport master (
      output req_valid, req_code, req_w0, req_w1, req_w2, req_w3, ch_ready,
      input  req_ready, ch_valid, ch_data
   );

   modport slave (
      input  req_valid, req_code, req_w0, req_w1, req_w2, req_w3, ch_ready,
      output req_ready, ch_valid, ch_data
   );
endinterface

// File: rtl/syscall_console_dec_digit.sv
// Decimal digit generator: repeated subtraction of powers of ten, leading zeros suppressed.
module syscall_dec_digit
   import syscall_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] mag_in,
   input  logic        digit_ack,
   output logic        digit_valid,
   output logic [3:0]  digit,
   output logic        last
);
   logic [31:0] mag;
   logic [31:0] pow;
   logic [3:0]  idx;
   logic [3:0]  cnt;
   logic        seen_nz;
   logic        run;
   logic        hold;

   assign pow = POW10[idx];

   always_ff @(posedge clk) begin
      if (reset) begin
         mag     <= '0;
         idx     <= '0;
         cnt     <= '0;
         seen_nz <= 1'b0;
         run     <= 1'b0;
         hold    <= 1'b0;
      end else if (start) begin
         mag     <= mag_in;
         idx     <= 4'd9;
         cnt     <= '0;
         seen_nz <= 1'b0;
         run     <= 1'b1;
         hold    <= 1'b0;
      end else if (run) begin
         if (hold) begin
            // digit is held stable until the top has handed it to the sink
            if (digit_ack) begin
               hold    <= 1'b0;
               seen_nz <= 1'b1;
               cnt     <= '0;
               if (idx == 4'd0) run <= 1'b0;
               else             idx <= idx - 4'd1;
            end
         end else if (mag >= pow && cnt != 4'd9) begin
            mag <= mag - pow;
            cnt <= cnt + 4'd1;
         end else if (cnt != 4'd0 || seen_nz || idx == 4'd0) begin
            hold <= 1'b1;
         end else begin
            idx <= idx - 4'd1;
         end
      end
   end

   assign digit_valid = hold;
   assign digit       = cnt;
   assign last        = (idx == 4'd0);

endmodule

// File: rtl/syscall_console.sv
// Syscall console: formats print/exit/nop requests into an ASCII byte stream with a sticky halt.
module syscall_console
   import syscall_pkg::*;
#(
   parameter bit NEWLINE_EN   = 1'b1,
   parameter bit STR_NUL_TERM = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   syscall_console_if.slave bus,
   output logic             halted,
   output logic             busy,
   output logic             bad_code
);
   state_t       state, state_nxt, done_st;
   logic [127:0] str_q;
   logic [4:0]   str_left;
   logic [7:0]   cur_byte;
   logic [31:0]  mag_in;
   logic         accept, ch_fire, int_code, neg, str_end;
   logic         dig_valid, dig_last, dig_ack;
   logic [3:0]   dig;

   assign accept   = bus.req_valid && bus.req_ready;
   assign ch_fire  = bus.ch_valid && bus.ch_ready;
   assign int_code = (bus.req_code == SYS_PRINT_INT) || (bus.req_code == SYS_PRINT_UINT);
   assign neg      = (bus.req_code == SYS_PRINT_INT) && bus.req_w0[31];
   assign mag_in   = neg ? (~bus.req_w0 + 32'd1) : bus.req_w0;
   assign cur_byte = str_q[127:120];
   assign str_end  = (str_left == 5'd0) || (STR_NUL_TERM && cur_byte == 8'h00);
   assign done_st  = NEWLINE_EN ? NL : IDLE;
   assign dig_ack  = (state == EMIT) && bus.ch_ready;

   syscall_dec_digit u_dec (
      .clk         (clk),
      .reset       (reset),
      .start       (accept && int_code),
      .mag_in      (mag_in),
      .digit_ack   (dig_ack),
      .digit_valid (dig_valid),
      .digit       (dig),
      .last        (dig_last)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) begin
            if (neg)                            state_nxt = SIGN;
            else if (int_code)                  state_nxt = DIGIT;
            else if (bus.req_code == SYS_EXIT)  state_nxt = HALT;
            else if (is_str(bus.req_code))      state_nxt = STR;
         end
         SIGN:  if (bus.ch_ready) state_nxt = DIGIT;
         DIGIT: if (dig_valid)    state_nxt = EMIT;
         EMIT:  if (bus.ch_ready) state_nxt = dig_last ? done_st : DIGIT;
         STR:   if (str_end || (bus.ch_ready && str_left == 5'd1)) state_nxt = done_st;
         NL:    if (bus.ch_ready) state_nxt = IDLE;
         HALT:  state_nxt = HALT;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready = 1'b0;
      bus.ch_valid  = 1'b0;
      bus.ch_data   = 8'h00;
      busy          = 1'b1;
      halted        = 1'b0;
      case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            busy          = 1'b0;
         end
         SIGN: begin
            bus.ch_valid = 1'b1;
            bus.ch_data  = ASCII_MINUS;
         end
         EMIT: begin
            bus.ch_valid = 1'b1;
            bus.ch_data  = ASCII_0 + {4'h0, dig};
         end
         STR: begin
            bus.ch_valid = !str_end;
            bus.ch_data  = str_end ? 8'h00 : cur_byte;
         end
         NL: begin
            bus.ch_valid = 1'b1;
            bus.ch_data  = ASCII_NL;
         end
         HALT: begin
            busy   = 1'b0;
            halted = 1'b1;
         end
         default: ;
      endcase
   end

   // string words shift left one byte per handshake so the next char is always the top byte
   always_ff @(posedge clk) begin
      if (reset) begin
         str_q    <= '0;
         str_left <= '0;
         bad_code <= 1'b0;
      end else begin
         bad_code <= accept && !code_known(bus.req_code);
         if (accept) begin
            str_q    <= {bus.req_w0, bus.req_w1, bus.req_w2, bus.req_w3};
            str_left <= is_str(bus.req_code) ? str_bytes(bus.req_code) : 5'd0;
         end else if (state == STR && ch_fire) begin
            str_q    <= {str_q[119:0], 8'h00};
            str_left <= str_left - 5'd1;
         end
      end
   end

endmodule

// File: tb/tb_syscall_console.sv
// Bench for syscall_console: directed vector table, random requests vs. a string-level model.
module tb_syscall_console;

   typedef struct {
      logic [31:0]  code;
      logic [31:0]  w0, w1, w2, w3;
      logic [159:0] exp;
      int           len;
      bit           nl;
      bit           bad;
      bit           rnd;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic halted, busy, bad_code;

   syscall_console_if bus();

   syscall_console #(.NEWLINE_EN(1'b1), .STR_NUL_TERM(1'b1)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .halted   (halted),
      .busy     (busy),
      .bad_code (bad_code)
   );

   always #5 clk = ~clk;

   int         tests = 0;
   int         fails = 0;
   logic [7:0] got[$];
   logic [7:0] exp_q[$];
   bit         exp_bad;
   int         bad_seen = 0;
   bit         rnd_ready = 1'b0;
   bit         prev_stall = 1'b0;
   logic [7:0] prev_data = 8'h00;

   always @(posedge clk) begin
      #1;
      bus.ch_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // sink side: collect handshaken bytes, check hold-while-stalled
   always @(negedge clk) begin
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            tests++;
            if (!(bus.ch_valid && bus.ch_data == prev_data)) begin
               fails++;
               $display("FAIL stall_hold: got valid=%0b data=%02h, need valid=1 data=%02h",
                        bus.ch_valid, bus.ch_data, prev_data);
            end
         end
         if (bus.ch_valid && bus.ch_ready) got.push_back(bus.ch_data);
         if (bad_code) bad_seen++;
         prev_stall = bus.ch_valid && !bus.ch_ready;
         prev_data  = bus.ch_data;
      end
   end

   function automatic string qstr(input logic [7:0] q[$]);
      string s = "";
      foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
      return s;
   endfunction

   // expected console output computed from the syscall semantics directly
   function automatic void build_exp(input logic [31:0] c, w0, w1, w2, w3);
      logic [31:0]      ws[4];
      longint unsigned  m;
      logic [7:0]       tmp[$];
      logic [7:0]       ch;
      bit               stop;
      exp_q.delete();
      exp_bad = 1'b0;
      ws = '{w0, w1, w2, w3};
      if (c == 32'd1 || c == 32'd8) begin
         m = {32'd0, w0};
         if (c == 32'd1 && w0[31]) begin
            exp_q.push_back(8'h2D);
            m = 64'h1_0000_0000 - {32'd0, w0};
         end
         tmp.push_front(8'h30 + 8'(m % 10));
         m = m / 10;
         while (m != 0) begin
            tmp.push_front(8'h30 + 8'(m % 10));
            m = m / 10;
         end
         foreach (tmp[i]) exp_q.push_back(tmp[i]);
         exp_q.push_back(8'h0A);
      end else if (c >= 32'd4 && c <= 32'd7) begin
         stop = 1'b0;
         for (int i = 0; i < int'(c) - 3; i++)
            for (int b = 3; b >= 0; b--) begin
               ch = ws[i][8*b +: 8];
               if (!stop) begin
                  if (ch == 8'h00) stop = 1'b1;
                  else exp_q.push_back(ch);
               end
            end
         exp_q.push_back(8'h0A);
      end else if (c != 32'd2 && c != 32'd3) begin
         exp_bad = 1'b1;
      end
   endfunction

   task automatic check_bit(input string name, input logic act, input logic req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0b, need %0b", name, act, req);
      end
   endtask

   task automatic check_stream(input string name);
      tests++;
      if (got.size() != exp_q.size() || qstr(got) != qstr(exp_q)) begin
         fails++;
         $display("FAIL %s: got [%s] need [%s]", name, qstr(got), qstr(exp_q));
      end
   endtask

   task automatic send(input logic [31:0] c, w0, w1, w2, w3);
      int n = 0;
      @(posedge clk); #1;
      while (!bus.req_ready && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      bus.req_valid = 1'b1;
      bus.req_code  = c;
      bus.req_w0 = w0; bus.req_w1 = w1; bus.req_w2 = w2; bus.req_w3 = w3;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      bus.req_code  = $urandom;
      bus.req_w0    = $urandom;
   endtask

   task automatic wait_idle(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         @(negedge clk);
         if (bus.req_ready) ok = 1'b1;
      end
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL %s_timeout: got no return to idle, need idle within 2000 cycles", name);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset(input int cycles);
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (cycles) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   vec_t        tv[14];
   logic [31:0] codes[12];
   logic [31:0] w[4];

   initial begin
      bus.req_valid = 1'b0;
      bus.req_code  = '0;
      bus.req_w0 = '0; bus.req_w1 = '0; bus.req_w2 = '0; bus.req_w3 = '0;
      bus.ch_ready  = 1'b1;

      tv[0]  = '{32'd1, 32'hFFFFFC17, 0, 0, 0, 160'("-1001"), 5, 1, 0, 0};
      tv[1]  = '{32'd8, 32'hFFFFFC17, 0, 0, 0, 160'("4294966295"), 10, 1, 0, 0};
      tv[2]  = '{32'd1, 32'h80000000, 0, 0, 0, 160'("-2147483648"), 11, 1, 0, 0};
      tv[3]  = '{32'd1, 32'd0, 0, 0, 0, 160'("0"), 1, 1, 0, 0};
      tv[4]  = '{32'd7, "ABCD", "EFGH", "IJKL", "MNOP", 160'("ABCDEFGHIJKLMNOP"), 16, 1, 0, 1};
      tv[5]  = '{32'd5, 32'h41420000, "WXYZ", 0, 0, 160'("AB"), 2, 1, 0, 0};
      tv[6]  = '{32'd3, 32'd55, 0, 0, 0, 160'(0), 0, 0, 0, 0};
      tv[7]  = '{32'd9, 32'd55, 0, 0, 0, 160'(0), 0, 0, 1, 0};
      tv[8]  = '{32'd1, 32'd7, 0, 0, 0, 160'("7"), 1, 1, 0, 0};
      tv[9]  = '{32'd8, 32'd0, 0, 0, 0, 160'("0"), 1, 1, 0, 1};
      tv[10] = '{32'd1, 32'h7FFFFFFF, 0, 0, 0, 160'("2147483647"), 10, 1, 0, 1};
      tv[11] = '{32'd6, "abcd", "efgh", 32'h00414243, 0, 160'("abcdefgh"), 8, 1, 0, 0};
      tv[12] = '{32'd4, "xyz!", "q", 0, 0, 160'("xyz!"), 4, 1, 0, 1};
      tv[13] = '{32'd0, 32'd1, 0, 0, 0, 160'(0), 0, 0, 1, 0};

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_bit("rst_req_ready", bus.req_ready, 1'b1);
      check_bit("rst_ch_valid", bus.ch_valid, 1'b0);
      check_bit("rst_ch_data_zero", bus.ch_data == 8'h00, 1'b1);
      check_bit("rst_halted", halted, 1'b0);
      check_bit("rst_busy", busy, 1'b0);
      check_bit("rst_bad_code", bad_code, 1'b0);

      foreach (tv[v]) begin
         got.delete();
         exp_q.delete();
         bad_seen  = 0;
         rnd_ready = tv[v].rnd;
         for (int k = tv[v].len - 1; k >= 0; k--) exp_q.push_back(tv[v].exp[8*k +: 8]);
         if (tv[v].nl) exp_q.push_back(8'h0A);
         send(tv[v].code, tv[v].w0, tv[v].w1, tv[v].w2, tv[v].w3);
         if (tv[v].code == 32'd3) check_bit("nop_busy", busy, 1'b0);
         wait_idle($sformatf("vec%0d", v));
         check_stream($sformatf("vec%0d_bytes", v));
         check_bit($sformatf("vec%0d_bad_code", v), bad_seen == 1, tv[v].bad);
         check_bit($sformatf("vec%0d_ready_after", v), bus.req_ready, 1'b1);
      end

      codes = '{32'd1, 32'd1, 32'd8, 32'd8, 32'd4, 32'd5, 32'd6, 32'd7,
                32'd3, 32'd9, 32'd0, 32'h80000001};
      for (int r = 0; r < 40; r++) begin
         logic [31:0] c;
         c = codes[$urandom_range(0, 11)];
         foreach (w[i]) w[i] = $urandom;
         if ($urandom_range(0, 2) == 0) w[0] = $urandom_range(0, 20);
         if ($urandom_range(0, 3) == 0) begin
            int wi, bi;
            wi = $urandom_range(0, 3);
            bi = $urandom_range(0, 3);
            w[wi][8*bi +: 8] = 8'h00;
         end
         got.delete();
         bad_seen  = 0;
         rnd_ready = 1'($urandom_range(0, 1));
         build_exp(c, w[0], w[1], w[2], w[3]);
         send(c, w[0], w[1], w[2], w[3]);
         wait_idle($sformatf("rnd%0d", r));
         check_stream($sformatf("rnd%0d_bytes_code%0d", r, c));
         check_bit($sformatf("rnd%0d_bad_code", r), bad_seen == 1, exp_bad);
      end

      // exit: sticky halt, requests ignored until reset
      rnd_ready = 1'b0;
      got.delete();
      send(32'd2, 32'd0, 0, 0, 0);
      @(negedge clk);
      check_bit("halt_set", halted, 1'b1);
      bus.req_valid = 1'b1;
      bus.req_code  = 32'd1;
      bus.req_w0    = 32'd5;
      begin
         int viol = 0;
         repeat (100) begin
            @(negedge clk);
            if (bus.req_ready || bus.ch_valid || !halted) viol++;
         end
         check_bit("halt_hold_100", viol == 0, 1'b1);
      end
      bus.req_valid = 1'b0;
      check_bit("halt_no_bytes", got.size() == 0, 1'b1);
      do_reset(2);
      @(negedge clk);
      check_bit("halt_reset_halted", halted, 1'b0);
      check_bit("halt_reset_ready", bus.req_ready, 1'b1);

      // reset in the middle of the digit search
      got.delete();
      send(32'd8, 32'hFFFFFC17, 0, 0, 0);
      check_bit("midrst_busy_before", busy, 1'b1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check_bit("midrst_ch_valid", bus.ch_valid, 1'b0);
      check_bit("midrst_idle", bus.req_ready && !busy, 1'b1);
      got.delete();
      build_exp(32'd1, 32'd7, 0, 0, 0);
      send(32'd1, 32'd7, 0, 0, 0);
      wait_idle("after_midrst");
      check_stream("after_midrst_bytes");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
